// File: rtl/mem_access_unit.sv
// MEM-stage front end for a word-only data cache: byte lane select/extension,
// byte-store read-modify-write, word alignment checks, stall generation and perf counters.
module mem_access_unit #(
    parameter bit SIGN_EXTEND_BYTE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_load,
    input  logic        req_store,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] load_data,
    output logic        pipe_stall,
    output logic        align_fault,
    output logic        dc_read_en,
    output logic        dc_write_en,
    output logic [31:0] dc_addr,
    output logic [31:0] dc_wdata,
    input  logic [31:0] dc_rdata,
    input  logic        dc_stall,
    output logic [31:0] perf_ld_count,
    output logic [31:0] perf_st_count,
    output logic [31:0] perf_stall_count
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic        ld_done, st_done;
    logic        misaligned;
    logic [7:0]  lane_byte;
    logic [31:0] byte_ext;
    logic [31:0] merged_word;

    // Lane extraction for byte loads and lane insertion for byte stores
    always_comb begin
        lane_byte   = dc_rdata[7:0];
        merged_word = dc_rdata;
        case (req_addr[1:0])
            2'd0: begin lane_byte = dc_rdata[7:0];   merged_word[7:0]   = req_wdata[7:0]; end
            2'd1: begin lane_byte = dc_rdata[15:8];  merged_word[15:8]  = req_wdata[7:0]; end
            2'd2: begin lane_byte = dc_rdata[23:16]; merged_word[23:16] = req_wdata[7:0]; end
            default: begin lane_byte = dc_rdata[31:24]; merged_word[31:24] = req_wdata[7:0]; end
        endcase
        byte_ext = SIGN_EXTEND_BYTE ? {{24{lane_byte[7]}}, lane_byte} : {24'd0, lane_byte};
    end

    assign misaligned = !req_byte && (req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            merge_q <= 32'd0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
        end
    end

    // Next state and cache/pipeline controls; reset masks every control output
    always_comb begin
        state_d     = state_q;
        merge_d     = merge_q;
        dc_read_en  = 1'b0;
        dc_write_en = 1'b0;
        dc_addr     = {req_addr[31:2], 2'b00};
        dc_wdata    = 32'd0;
        pipe_stall  = 1'b0;
        align_fault = 1'b0;
        load_data   = 32'd0;
        ld_done     = 1'b0;
        st_done     = 1'b0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if ((req_load || req_store) && misaligned) begin
                        align_fault = 1'b1;
                    end else if (req_load) begin
                        dc_read_en = 1'b1;
                        pipe_stall = dc_stall;
                        if (!dc_stall) begin
                            ld_done   = 1'b1;
                            load_data = req_byte ? byte_ext : dc_rdata;
                        end
                    end else if (req_store && !req_byte) begin
                        dc_write_en = 1'b1;
                        dc_wdata    = req_wdata;
                        pipe_stall  = dc_stall;
                        st_done     = !dc_stall;
                    end else if (req_store) begin
                        // Read phase of a byte store always stalls; the write follows in RMW_WR
                        dc_read_en = 1'b1;
                        pipe_stall = 1'b1;
                        if (!dc_stall) begin
                            merge_d = merged_word;
                            state_d = RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    dc_write_en = 1'b1;
                    dc_wdata    = merge_q;
                    pipe_stall  = dc_stall;
                    if (!dc_stall) begin
                        st_done = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Free-running performance counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ld_count    <= 32'd0;
            perf_st_count    <= 32'd0;
            perf_stall_count <= 32'd0;
        end else begin
            if (ld_done)    perf_ld_count    <= perf_ld_count + 32'd1;
            if (st_done)    perf_st_count    <= perf_st_count + 32'd1;
            if (pipe_stall) perf_stall_count <= perf_stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small cache model: 11-cycle read miss,
// 10-cycle write stall, write-through to a word memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_load, req_store, req_byte;
    logic [31:0] req_addr, req_wdata;
    logic [31:0] load_data;
    logic        pipe_stall, align_fault;
    logic        dc_read_en, dc_write_en;
    logic [31:0] dc_addr, dc_wdata, dc_rdata;
    logic        dc_stall;
    logic [31:0] perf_ld_count, perf_st_count, perf_stall_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];
    logic        resident [0:63];
    int          miss_cnt, wr_cnt, n_reads, n_writes;
    int          stalls, rd0, wr0;

    always #5 clk = ~clk;

    mem_access_unit #(.SIGN_EXTEND_BYTE(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_load(req_load), .req_store(req_store), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .load_data(load_data), .pipe_stall(pipe_stall), .align_fault(align_fault),
        .dc_read_en(dc_read_en), .dc_write_en(dc_write_en),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_stall(dc_stall),
        .perf_ld_count(perf_ld_count), .perf_st_count(perf_st_count),
        .perf_stall_count(perf_stall_count)
    );

    assign dc_stall = (dc_read_en && !resident[dc_addr[9:4]]) || (dc_write_en && wr_cnt != 10);
    assign dc_rdata = mem[dc_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: sample the cache request before the edge, update the cache model after it
    task automatic tick();
        logic        c_rd, c_wr, c_st, c_rst;
        logic [31:0] c_addr, c_wd;
        #1;
        c_rd = dc_read_en; c_wr = dc_write_en; c_st = dc_stall; c_rst = reset;
        c_addr = dc_addr; c_wd = dc_wdata;
        @(posedge clk);
        #1;
        if (c_rst) begin
            miss_cnt = 0;
            wr_cnt   = 0;
        end else if (c_rd) begin
            if (!resident[c_addr[9:4]]) begin
                if (miss_cnt == 10) begin
                    resident[c_addr[9:4]] = 1'b1;
                    miss_cnt = 0;
                end else begin
                    miss_cnt++;
                end
            end else begin
                n_reads++;
            end
        end else if (c_wr) begin
            if (c_st) begin
                wr_cnt++;
            end else begin
                mem[c_addr[9:2]] = c_wd;
                n_writes++;
                wr_cnt = 0;
            end
        end
    endtask

    // Count stalled cycles until the first non-stalled one (bounded)
    task automatic run_stalled(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!pipe_stall) break;
            n++;
            tick();
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic bt,
                         input logic [31:0] a, input logic [31:0] d);
        req_load = ld; req_store = st; req_byte = bt; req_addr = a; req_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 64; i++) resident[i] = 1'b0;
        mem[32'h40 >> 2]  = 32'h1122C344;
        mem[32'h80 >> 2]  = 32'hDEADBEEF;
        mem[32'h100 >> 2] = 32'h00000000;
        resident[32'h40 >> 4] = 1'b1;
        miss_cnt = 0; wr_cnt = 0; n_reads = 0; n_writes = 0;

        reset = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        tick();
        tick();
        #1;
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        chk("rst_read_en", 32'(dc_read_en), 32'd0);
        chk("rst_ld_count", perf_ld_count, 32'd0);
        chk("rst_stall_count", perf_stall_count, 32'd0);
        reset = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        #1;
        chk("idle_read_en", 32'(dc_read_en), 32'd0);
        chk("idle_load_data", load_data, 32'd0);

        // Byte loads and a word load from a resident line
        issue(1'b1, 1'b0, 1'b1, 32'h41, 32'd0);
        #1;
        chk("lb41_data", load_data, 32'hFFFFFFC3);
        chk("lb41_stall", 32'(pipe_stall), 32'd0);
        chk("lb41_ld_before", perf_ld_count, 32'd0);
        tick();
        chk("lb41_ld_after", perf_ld_count, 32'd1);
        issue(1'b1, 1'b0, 1'b1, 32'h43, 32'd0);
        #1;
        chk("lb43_data", load_data, 32'h00000011);
        chk("lb43_stall", 32'(pipe_stall), 32'd0);
        tick();
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        #1;
        chk("lw40_data", load_data, 32'h1122C344);
        chk("lw40_addr", dc_addr, 32'h40);
        tick();
        chk("hits_ld_count", perf_ld_count, 32'd3);
        chk("hits_stall_count", perf_stall_count, 32'd0);

        // Word load miss
        issue(1'b1, 1'b0, 1'b0, 32'h80, 32'd0);
        run_stalled(stalls);
        chk("lw80_stalls", 32'(stalls), 32'd11);
        chk("lw80_data", load_data, 32'hDEADBEEF);
        tick();
        chk("lw80_stall_count", perf_stall_count, 32'd11);
        chk("lw80_ld_count", perf_ld_count, 32'd4);

        // Byte store hit: read-modify-write
        rd0 = n_reads; wr0 = n_writes;
        issue(1'b0, 1'b1, 1'b1, 32'h42, 32'h000000AB);
        run_stalled(stalls);
        chk("sb42_stalls", 32'(stalls), 32'd11);
        chk("sb42_write_en", 32'(dc_write_en), 32'd1);
        chk("sb42_wdata", dc_wdata, 32'h11ABC344);
        tick();
        chk("sb42_mem", mem[32'h40 >> 2], 32'h11ABC344);
        chk("sb42_reads", 32'(n_reads - rd0), 32'd1);
        chk("sb42_writes", 32'(n_writes - wr0), 32'd1);
        chk("sb42_st_count", perf_st_count, 32'd1);
        chk("sb42_stall_count", perf_stall_count, 32'd22);

        // Byte store miss, only wdata[7:0] lands
        issue(1'b0, 1'b1, 1'b1, 32'h100, 32'hFFFFFF5A);
        run_stalled(stalls);
        chk("sb100_stalls", 32'(stalls), 32'd22);
        tick();
        chk("sb100_mem", mem[32'h100 >> 2], 32'h0000005A);
        chk("sb100_st_count", perf_st_count, 32'd2);
        chk("sb100_stall_count", perf_stall_count, 32'd44);

        // Misaligned word accesses
        issue(1'b1, 1'b0, 1'b0, 32'h42, 32'd0);
        #1;
        chk("lw42_fault", 32'(align_fault), 32'd1);
        chk("lw42_read_en", 32'(dc_read_en), 32'd0);
        chk("lw42_stall", 32'(pipe_stall), 32'd0);
        tick();
        issue(1'b0, 1'b1, 1'b0, 32'h41, 32'h12345678);
        #1;
        chk("sw41_fault", 32'(align_fault), 32'd1);
        chk("sw41_write_en", 32'(dc_write_en), 32'd0);
        tick();
        chk("mis_ld_count", perf_ld_count, 32'd4);
        chk("mis_st_count", perf_st_count, 32'd2);
        chk("mis_stall_count", perf_stall_count, 32'd44);

        // Reset in the third RMW_WR cycle abandons the write
        wr0 = n_writes;
        issue(1'b0, 1'b1, 1'b1, 32'h40, 32'h00000077);
        tick();
        tick();
        tick();
        #1;
        chk("rmw3_write_en", 32'(dc_write_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmwrst_write_en", 32'(dc_write_en), 32'd0);
        chk("rmwrst_read_en", 32'(dc_read_en), 32'd0);
        chk("rmwrst_stall", 32'(pipe_stall), 32'd0);
        chk("rmwrst_fault", 32'(align_fault), 32'd0);
        chk("rmwrst_load_data", load_data, 32'd0);
        tick();
        chk("rmwrst_st_count", perf_st_count, 32'd0);
        chk("rmwrst_stall_count", perf_stall_count, 32'd0);
        reset = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("rmwrst_mem", mem[32'h40 >> 2], 32'h11ABC344);
        chk("rmwrst_writes", 32'(n_writes - wr0), 32'd0);
        issue(1'b1, 1'b0, 1'b0, 32'h40, 32'd0);
        #1;
        chk("post_rst_data", load_data, 32'h11ABC344);
        chk("post_rst_stall", 32'(pipe_stall), 32'd0);
        tick();
        chk("post_rst_ld_count", perf_ld_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Pipeline MEM-stage front end sitting directly upstream of the data cache: it accepts the load/store issued by the EX/MEM register and turns it into word-only cache requests. It handles byte loads (lane select plus extension), byte stores (read-modify-write over the word cache port), word-alignment checks and pipeline stall generation. It also keeps free-running access and stall performance counters.

## Interface
Parameters:
- SIGN_EXTEND_BYTE, 1: 1 = byte loads sign-extend bit 7; 0 = zero-extend.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_load  in  1  load request from EX/MEM; held stable while pipe_stall=1.
- req_store  in  1  store request; never asserted together with req_load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; a byte store uses bits [7:0].
- load_data  out  32  load result; valid in the cycle a load completes with pipe_stall=0.
- pipe_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- align_fault  out  1  word access with req_addr[1:0]!=0.
- dc_read_en  out  1  cache load request.
- dc_write_en  out  1  cache store request.
- dc_addr  out  32  cache address, always word-aligned ({addr[31:2],2'b00}).
- dc_wdata  out  32  cache store data.
- dc_rdata  in  32  cache load data.
- dc_stall  in  1  cache busy; combinational from the current request.
- perf_ld_count  out  32  completed loads.
- perf_st_count  out  32  completed stores.
- perf_stall_count  out  32  cycles with pipe_stall=1.

## Operation
- FSM states: IDLE and RMW_WR. The merged word is held in register merge_q (32 bits).
- IDLE, word load: dc_read_en=1. pipe_stall=dc_stall. The load completes when dc_stall=0, with load_data=dc_rdata.
- IDLE, byte load: dc_read_en=1. The lane is chosen by addr[1:0], little-endian (00 selects [7:0], 11 selects [31:24]). The byte is extended per SIGN_EXTEND_BYTE. Completion works as for a word load.
- IDLE, word store: dc_write_en=1, dc_wdata=req_wdata, pipe_stall=dc_stall. The store completes when dc_stall=0.
- IDLE, byte store (read phase):
  - dc_read_en=1 and pipe_stall=1 unconditionally.
  - When dc_stall=0: merge_q is loaded with dc_rdata, with the addressed lane replaced by req_wdata[7:0], and the FSM moves to RMW_WR.
- RMW_WR:
  - dc_write_en=1, dc_wdata=merge_q, pipe_stall=dc_stall.
  - When dc_stall=0, the store completes and the FSM returns to IDLE.
- Misaligned word access (req_byte=0, addr[1:0]!=0):
  - align_fault=1 combinationally.
  - No cache enable is raised, pipe_stall=0, counters unchanged, FSM stays in IDLE.
  - Byte accesses never fault.
- No request in IDLE: all enables 0, pipe_stall=0, load_data=0.
- Only one of dc_read_en or dc_write_en is ever asserted at a time.
- Counters:
  - 32-bit, wrap modulo 2^32.
  - perf_ld_count and perf_st_count increment once, in the completion cycle.
  - A byte store counts once.
  - Reset clears all three counters.
- Reset:
  - While reset=1: state=IDLE, merge_q=0, all counters 0.
  - dc_read_en, dc_write_en, pipe_stall, align_fault and load_data are forced to 0.
  - Reset during RMW_WR abandons the write; the unit shares reset with the data cache.

## Timing
- Load hit: zero added latency; completes in its issue cycle.
- Load miss (cache 10-cycle refill): pipe_stall is high for 11 cycles; data appears in the 12th cycle.
- Word store: pipe_stall is high for 10 cycles and low in the 11th, the completion cycle.
- Byte store, hit:
  - 1-cycle read phase (stall high), then 10 stall cycles in RMW_WR.
  - Total: 11 cycles high, completion in the 12th.
- Byte store, miss: 12 cycles high for the read phase (including the refill), then 10 in RMW_WR. Total: 22 cycles high, completion in the 23rd.
- perf_stall_count reflects a stall cycle on the following clock edge.

## Test plan
- Cache word 0x40 = 0x1122C344 (line resident); byte load 0x41, SIGN_EXTEND_BYTE=1 -> load_data=0xFFFFFFC3, pipe_stall=0, perf_ld_count 0->1.
- Same line; byte load 0x43 -> 0x00000011. Word load 0x40 -> 0x1122C344, both with zero stall cycles.
- Cold cache; word load 0x80 (mem 0xDEADBEEF) -> pipe_stall high for exactly 11 cycles, load_data=0xDEADBEEF in cycle 12, perf_stall_count=11.
- Resident word 0x40 = 0x1122C344; byte store 0x42 data 0x000000AB:
  - exactly one read then one write reaches the cache;
  - memory and cache word 0x40 become 0x11ABC344;
  - pipe_stall high for 11 cycles;
  - perf_st_count=1.
- Byte store to non-resident 0x100 (mem 0x00000000), data 0x5A at offset 0 -> mem 0x0000005A, stall exactly 22 cycles.
- Word load 0x42 -> align_fault=1, dc_read_en=0, pipe_stall=0, counters unchanged. Reset asserted in cycle 3 of RMW_WR -> no memory write, all outputs 0.
